program_sequencer: RTL and testbench

Instruction-issue stage sitting directly upstream of the 16-bit CPU. It fetches 16-bit instruction words from a synchronous program ROM, presents each word on the CPU's `din` with a one-cycle `run` pulse, and waits for the CPU's `Done` before fetching the next word. It stops on a halt marker or at the end of the program space, and flags an error if the CPU fails to complete within a bounded time.

---
 rtl/cpu_defs.sv | 18 +
 rtl/exec_watchdog.sv | 31 +++
 rtl/program_sequencer.sv | 134 +++++++++++++
 tb/tb_program_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Definitions shared by the 16-bit CPU, its issue stage and their benches:
// instruction width, end-of-program marker and sequencer state encoding.
package cpu_defs;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_ISSUE  = 3'd3,
        S_EXEC   = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } seq_state_t;

endpackage

// File: rtl/exec_watchdog.sv
// Counts EXEC cycles spent waiting for the CPU; terminal marks the cycle in
// which the count steps onto TIMEOUT-1.
module exec_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PRE  = CW'(TIMEOUT - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = enable && (count == PRE);

endmodule

// File: rtl/program_sequencer.sv
// Instruction-issue stage: fetches words from a synchronous ROM, hands each to
// the CPU with a one-cycle run strobe and waits for Done before the next fetch.
module program_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int TIMEOUT = 64,
    parameter logic [DATA_W-1:0] HALT_WORD = cpu_defs::HALT_WORD
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] din,
    output logic              run,
    input  logic              Done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [2:0]        state
);

    import cpu_defs::*;

    // CPU handshake: run is a one-cycle strobe with din already stable; din
    // then holds until the edge after Done, and Done only counts in EXEC.

    seq_state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] din_q;
    logic [15:0]       retired_q;

    logic restart, pc_inc, din_ld, retire, wd_clear, wd_en, wd_terminal;

    exec_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (wd_clear),
        .enable   (wd_en),
        .terminal (wd_terminal)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        pc_inc   = 1'b0;
        din_ld   = 1'b0;
        retire   = 1'b0;
        wd_clear = 1'b0;
        wd_en    = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    restart = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rdata == HALT_WORD) begin
                    state_d = S_HALTED;
                end else begin
                    din_ld  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_clear = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                // Done is checked first so it beats a coincident timeout.
                if (Done) begin
                    retire = 1'b1;
                    if (&pc_q) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_terminal) begin
                        state_d = S_ERROR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q      <= '0;
            din_q     <= '0;
            retired_q <= '0;
        end else begin
            if (restart) begin
                pc_q      <= '0;
                retired_q <= '0;
            end else begin
                if (pc_inc) pc_q <= pc_q + ADDR_W'(1);
                if (retire) retired_q <= retired_q + 16'd1;
            end
            if (din_ld) din_q <= mem_rdata;
        end
    end

    assign mem_en   = (state_q == S_FETCH);
    assign run      = (state_q == S_ISSUE);
    assign busy     = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                      (state_q == S_ISSUE) || (state_q == S_EXEC);
    assign halted   = (state_q == S_HALTED);
    assign error    = (state_q == S_ERROR);
    assign pc       = pc_q;
    assign mem_addr = pc_q;
    assign din      = din_q;
    assign retired  = retired_q;
    assign state    = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: per-cycle vector table on an 8-bit
// address instance, plus hand sequences for async reset and end of space.
module tb_program_sequencer;

    localparam logic [4:0] O_IDLE  = 5'b00000;  // {mem_en, run, busy, halted, error}
    localparam logic [4:0] O_FETCH = 5'b10100;
    localparam logic [4:0] O_WAIT  = 5'b00100;
    localparam logic [4:0] O_ISSUE = 5'b01100;
    localparam logic [4:0] O_EXEC  = 5'b00100;
    localparam logic [4:0] O_HALT  = 5'b00010;
    localparam logic [4:0] O_ERR   = 5'b00001;

    typedef struct {
        logic        start;
        logic        done;
        logic [4:0]  ctl;
        logic [7:0]  pc;
        logic [15:0] din;
        logic [15:0] ret;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1: ADDR_W=8, TIMEOUT=8 ----------------
    logic        start = 1'b0, done = 1'b0;
    logic        mem_en, run, busy, halted, error;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_rdata = 16'h0, din, retired;
    logic [2:0]  dbg_state;
    logic [15:0] rom [256];

    program_sequencer #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(8), .HALT_WORD(16'hFFFF)) dut (
        .clk(clk), .resetn(resetn), .start(start), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .din(din), .run(run), .Done(done), .pc(pc),
        .retired(retired), .busy(busy), .halted(halted), .error(error), .state(dbg_state)
    );

    always @(posedge clk) if (mem_en) mem_rdata <= rom[mem_addr];

    // ---------------- DUT 2: ADDR_W=2, CPU answers one cycle after run ----------------
    logic        start2 = 1'b0, done2;
    logic        mem_en2, run2, busy2, halted2, error2;
    logic [1:0]  mem_addr2, pc2;
    logic [15:0] mem_rdata2 = 16'h0, din2, retired2;
    logic [2:0]  dbg_state2;
    logic [15:0] rom2 [4];

    program_sequencer #(.ADDR_W(2), .DATA_W(16), .TIMEOUT(8), .HALT_WORD(16'hFFFF)) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .mem_en(mem_en2), .mem_addr(mem_addr2),
        .mem_rdata(mem_rdata2), .din(din2), .run(run2), .Done(done2), .pc(pc2),
        .retired(retired2), .busy(busy2), .halted(halted2), .error(error2), .state(dbg_state2)
    );

    always @(posedge clk) if (mem_en2) mem_rdata2 <= rom2[mem_addr2];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) done2 <= 1'b0;
        else         done2 <= run2;
    end

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vecs[$];
    int          seg[6];
    logic [15:0] exp_q[$];
    logic [15:0] bb[3];

    function automatic void add(input logic st, input logic dn, input logic [4:0] ctl,
                                input int p, input logic [15:0] d, input int r);
        vec_t v;
        v.start = st; v.done = dn; v.ctl = ctl;
        v.pc = 8'(p); v.din = d; v.ret = 16'(r);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3);
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    // ---------------- driver: one table row per cycle ----------------
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            logic [4:0] ctl;
            @(negedge clk);
            ctl = {mem_en, run, busy, halted, error};
            n_vec++;
            if (ctl !== vecs[i].ctl || pc !== vecs[i].pc || mem_addr !== vecs[i].pc ||
                din !== vecs[i].din || retired !== vecs[i].ret) begin
                n_bad++;
                $display("FAIL vec%0d: ctl=%b pc=%0h addr=%0h din=%h ret=%0d, want ctl=%b pc=%0h din=%h ret=%0d",
                         i, ctl, pc, mem_addr, din, retired,
                         vecs[i].ctl, vecs[i].pc, vecs[i].din, vecs[i].ret);
            end
            start = vecs[i].start;
            done  = vecs[i].done;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc, runs;
        logic got_halt;
        logic [15:0] prev;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0;
        bb[0] = 16'h1234; bb[1] = 16'h5678; bb[2] = 16'h9ABC;

        // Basic issue: one instruction, Done two cycles after run, then halt marker.
        seg[0] = vecs.size();
        add(1, 0, O_IDLE,  0, 16'h0000, 0);
        add(0, 0, O_FETCH, 0, 16'h0000, 0);
        add(0, 0, O_WAIT,  0, 16'h0000, 0);
        add(0, 0, O_ISSUE, 0, 16'h1234, 0);
        add(0, 0, O_EXEC,  0, 16'h1234, 0);
        add(0, 1, O_EXEC,  0, 16'h1234, 0);
        add(0, 0, O_FETCH, 1, 16'h1234, 1);
        add(0, 0, O_WAIT,  1, 16'h1234, 1);
        add(0, 0, O_HALT,  1, 16'h1234, 1);
        add(0, 0, O_HALT,  1, 16'h1234, 1);

        // Back-to-back: Done right after each run, runs 4 cycles apart.
        seg[1] = vecs.size();
        add(1, 0, O_HALT, 1, 16'h1234, 1);
        prev = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            add(0, 0, O_FETCH, k, prev, k);
            add(0, 0, O_WAIT,  k, prev, k);
            add(0, 0, O_ISSUE, k, bb[k], k);
            add(0, 1, O_EXEC,  k, bb[k], k);
            prev = bb[k];
        end
        add(0, 0, O_FETCH, 3, prev, 3);
        add(0, 0, O_WAIT,  3, prev, 3);
        add(0, 0, O_HALT,  3, prev, 3);

        // Ignored inputs: start held while busy, Done outside EXEC.
        seg[2] = vecs.size();
        add(1, 0, O_HALT,  3, 16'h9ABC, 3);
        add(1, 1, O_FETCH, 0, 16'h9ABC, 0);
        add(1, 1, O_WAIT,  0, 16'h9ABC, 0);
        add(1, 1, O_ISSUE, 0, 16'h1111, 0);
        add(1, 0, O_EXEC,  0, 16'h1111, 0);
        add(1, 0, O_EXEC,  0, 16'h1111, 0);
        add(0, 1, O_EXEC,  0, 16'h1111, 0);
        add(0, 0, O_FETCH, 1, 16'h1111, 1);
        add(0, 0, O_WAIT,  1, 16'h1111, 1);
        add(0, 0, O_HALT,  1, 16'h1111, 1);

        // Timeout: no Done, ERROR 8 cycles after ISSUE, then restart from ERROR.
        seg[3] = vecs.size();
        add(1, 0, O_HALT,  1, 16'h1111, 1);
        add(0, 0, O_FETCH, 0, 16'h1111, 0);
        add(0, 0, O_WAIT,  0, 16'h1111, 0);
        add(0, 0, O_ISSUE, 0, 16'h2222, 0);
        for (int k = 0; k < 7; k++) add(0, 0, O_EXEC, 0, 16'h2222, 0);
        add(0, 0, O_ERR,   0, 16'h2222, 0);
        add(1, 0, O_ERR,   0, 16'h2222, 0);
        add(0, 0, O_FETCH, 0, 16'h2222, 0);
        add(0, 0, O_WAIT,  0, 16'h2222, 0);
        add(0, 0, O_ISSUE, 0, 16'h2222, 0);
        add(0, 1, O_EXEC,  0, 16'h2222, 0);
        add(0, 0, O_FETCH, 1, 16'h2222, 1);
        add(0, 0, O_WAIT,  1, 16'h2222, 1);
        add(0, 0, O_HALT,  1, 16'h2222, 1);

        // Done in the very cycle the watchdog would expire: Done wins.
        seg[4] = vecs.size();
        add(1, 0, O_HALT,  1, 16'h2222, 1);
        add(0, 0, O_FETCH, 0, 16'h2222, 0);
        add(0, 0, O_WAIT,  0, 16'h2222, 0);
        add(0, 0, O_ISSUE, 0, 16'h3333, 0);
        for (int k = 0; k < 6; k++) add(0, 0, O_EXEC, 0, 16'h3333, 0);
        add(0, 1, O_EXEC,  0, 16'h3333, 0);
        add(0, 0, O_FETCH, 1, 16'h3333, 1);
        add(0, 0, O_WAIT,  1, 16'h3333, 1);
        add(0, 0, O_HALT,  1, 16'h3333, 1);
        seg[5] = vecs.size();

        repeat (3) @(negedge clk);
        resetn = 1'b1;

        load(16'h1234, 16'hFFFF, 16'h0000, 16'h0000);
        run_vecs(seg[0], seg[1]);
        load(16'h1234, 16'h5678, 16'h9ABC, 16'hFFFF);
        run_vecs(seg[1], seg[2]);
        load(16'h1111, 16'hFFFF, 16'h0000, 16'h0000);
        run_vecs(seg[2], seg[3]);
        load(16'h2222, 16'hFFFF, 16'h0000, 16'h0000);
        run_vecs(seg[3], seg[4]);
        load(16'h3333, 16'hFFFF, 16'h0000, 16'h0000);
        run_vecs(seg[4], seg[5]);

        // Async reset in the middle of the second instruction's EXEC.
        load(16'h4444, 16'h5555, 16'hFFFF, 16'hFFFF);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_run0", {15'h0, run, din}, {15'h0, 1'b1, 16'h4444});
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_run1", {15'h0, run, din}, {15'h0, 1'b1, 16'h5555});
        @(negedge clk);
        check("rst_pre_exec", {busy, run, 14'h0, retired}, {1'b1, 1'b0, 14'h0, 16'd1});
        #2 resetn = 1'b0;
        #1;
        check("rst_ctl", {27'h0, mem_en, run, busy, halted, error}, 32'h0);
        check("rst_pc", {24'h0, pc}, 32'h0);
        check("rst_din", {16'h0, din}, 32'h0);
        check("rst_retired", {16'h0, retired}, 32'h0);
        @(negedge clk); resetn = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("rst_refetch", {23'h0, mem_en, mem_addr}, {23'h0, 1'b1, 8'h00});
        @(negedge clk);
        @(negedge clk);
        check("rst_rerun", {15'h0, run, din}, {15'h0, 1'b1, 16'h4444});

        // End of program space on the 2-bit address instance.
        for (int i = 0; i < 4; i++) begin
            rom2[i] = 16'hA000 + 16'(i);
            exp_q.push_back(16'hA000 + 16'(i));
        end
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cyc = 1; runs = 0; got_halt = 1'b0;
        while (cyc <= 40 && !got_halt) begin
            if (run2) begin
                runs++;
                if (exp_q.size() == 0) check("eos_extra_run", 32'd1, 32'd0);
                else check("eos_din", {16'h0, din2}, {16'h0, exp_q.pop_front()});
            end
            if (halted2) got_halt = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("eos_halt_reached", {31'h0, got_halt}, 32'd1);
        check("eos_halt_cycle", cyc, 32'd17);
        check("eos_runs", runs, 32'd4);
        check("eos_retired", {16'h0, retired2}, 32'd4);
        check("eos_pc", {30'h0, pc2}, 32'd3);
        check("eos_flags", {29'h0, busy2, halted2, error2}, 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
